// File: rtl/led_counter_gen.sv
// Parametrised LED counter with a prescaled step and up, down, one-hot bounce and hold modes.
// Define LEDCNT_SAT_EN to make the up and down modes saturate instead of wrapping.
module led_counter_gen #(
  parameter int unsigned      WIDTH    = 8,
  parameter int unsigned      PRESCALE = 1,
  parameter logic [WIDTH-1:0] INIT     = '0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic [1:0]       mode_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  output logic [WIDTH-1:0] led_o,
  output logic             wrap_o
);

  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [WIDTH-1:0] ONES = '1;
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

  typedef enum logic [1:0] {
    MODE_UP     = 2'b00,
    MODE_DOWN   = 2'b01,
    MODE_BOUNCE = 2'b10,
    MODE_HOLD   = 2'b11
  } mode_e;

  typedef enum logic {
    DIR_LEFT  = 1'b0,
    DIR_RIGHT = 1'b1
  } dir_e;

  logic [WIDTH-1:0] led_q, led_d;
  logic             wrap_q, wrap_d;
  logic [PW-1:0]    pcnt_q, pcnt_d;
  dir_e             dir_q, dir_d;
  logic             tick;
  logic             onehot;

  assign tick   = en_i && (pcnt_q == PW'(PRESCALE - 1));
  assign onehot = (led_q != '0) && ((led_q & (led_q - ONE)) == '0);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      led_q  <= INIT;
      wrap_q <= 1'b0;
      pcnt_q <= '0;
      dir_q  <= DIR_LEFT;
    end else begin
      led_q  <= led_d;
      wrap_q <= wrap_d;
      pcnt_q <= pcnt_d;
      dir_q  <= dir_d;
    end
  end

  always_comb begin
    led_d  = led_q;
    wrap_d = 1'b0;
    pcnt_d = pcnt_q;
    dir_d  = dir_q;

    if (en_i) pcnt_d = tick ? '0 : pcnt_q + PW'(1);

    // A load restarts the step period and swallows any tick on the same edge.
    if (load_i) begin
      led_d  = load_val_i;
      pcnt_d = '0;
      if (mode_e'(mode_i) == MODE_BOUNCE) dir_d = DIR_LEFT;
    end else if (tick) begin
      case (mode_e'(mode_i))
        MODE_UP: begin
`ifdef LEDCNT_SAT_EN
          if (led_q != ONES) begin
            led_d  = led_q + ONE;
            wrap_d = (led_q == (ONES - ONE));
          end
`else
          led_d  = led_q + ONE;
          wrap_d = (led_q == ONES);
`endif
        end
        MODE_DOWN: begin
`ifdef LEDCNT_SAT_EN
          if (led_q != '0) begin
            led_d  = led_q - ONE;
            wrap_d = (led_q == ONE);
          end
`else
          led_d  = led_q - ONE;
          wrap_d = (led_q == '0);
`endif
        end
        MODE_BOUNCE: begin
          // Recover from a corrupted pattern by restarting at bit 0.
          if (!onehot) begin
            led_d = ONE;
            dir_d = DIR_LEFT;
          end else if (dir_q == DIR_LEFT && led_q[WIDTH-1]) begin
            dir_d  = DIR_RIGHT;
            led_d  = led_q >> 1;
            wrap_d = 1'b1;
          end else if (dir_q == DIR_RIGHT && led_q[0]) begin
            dir_d  = DIR_LEFT;
            led_d  = led_q << 1;
            wrap_d = 1'b1;
          end else begin
            led_d = (dir_q == DIR_LEFT) ? (led_q << 1) : (led_q >> 1);
          end
        end
        default: ;
      endcase
    end
  end

  assign led_o  = led_q;
  assign wrap_o = wrap_q;

endmodule
